// File: rtl/v6525_pkg.sv
// rtl/v6525_pkg.sv - register map and control-register bit positions for the 6525-style PIO
package v6525_pkg;

  localparam logic [2:0] REG_PRA  = 3'd0;
  localparam logic [2:0] REG_PRB  = 3'd1;
  localparam logic [2:0] REG_PRC  = 3'd2;
  localparam logic [2:0] REG_DDRA = 3'd3;
  localparam logic [2:0] REG_DDRB = 3'd4;
  localparam logic [2:0] REG_DDRC = 3'd5;
  localparam logic [2:0] REG_CR   = 3'd6;
  localparam logic [2:0] REG_AIR  = 3'd7;

  localparam int CR_MC = 0;
  localparam int CR_EP = 1;
  localparam int CR_W  = 2;

endpackage

// File: rtl/v6525_pio_if.sv
// rtl/v6525_pio_if.sv - CPU register bus of the PIO
interface v6525_pio_if #(
  parameter int WIDTH = 8
);
  logic             cs;
  logic             r_w;
  logic [2:0]       rs;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_oe;

  modport master (output cs, r_w, rs, data_in, input  data_out, data_oe);
  modport slave  (input  cs, r_w, rs, data_in, output data_out, data_oe);
endinterface

// File: rtl/v6525_port.sv
// rtl/v6525_port.sv - one bidirectional port: PR, DDR, pin drive and read-back mux
module v6525_port #(
  parameter int WIDTH = 8
) (
  input  logic             phi2,
  input  logic             reset,
  input  logic             wr_pr,
  input  logic             wr_ddr,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] ddr,
  output logic [WIDTH-1:0] port_out,
  output logic [WIDTH-1:0] port_oe,
  output logic [WIDTH-1:0] rd_val
);

  logic [WIDTH-1:0] pr;

  // PR and DDR load from the CPU bus; reset wins over any write
  always_ff @(posedge phi2) begin
    if (reset) begin
      pr  <= '0;
      ddr <= '0;
    end else begin
      if (wr_pr)  pr  <= data_in;
      if (wr_ddr) ddr <= data_in;
    end
  end

  assign port_out = pr;
  assign port_oe  = ddr;
  // output bits read back the latch, input bits read the pin
  assign rd_val   = (ddr & pr) | (~ddr & pin);

endmodule

// File: rtl/v6525_pio.sv
// rtl/v6525_pio.sv - three-port PIO with edge-latched port C interrupts and priority AIR
module v6525_pio
  import v6525_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIRQ  = 5
) (
  input  logic             phi2,
  input  logic             reset,
  v6525_pio_if.slave       bus,
  input  logic [WIDTH-1:0] pa_in,
  input  logic [WIDTH-1:0] pb_in,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] pa_out,
  output logic [WIDTH-1:0] pb_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pa_oe,
  output logic [WIDTH-1:0] pb_oe,
  output logic [WIDTH-1:0] pc_oe
);

  logic             wr, rd;
  logic [WIDTH-1:0] ddra, ddrb, ddrc;
  logic [WIDTH-1:0] pra_rd, prb_rd, prc_rd;
  logic [WIDTH-1:0] pc_out_port, pc_oe_port;
  logic [CR_W-1:0]  cr;
  logic             mc, ep, mc_drop, air_rd, irq_act;
  logic [NIRQ-1:0]  sync1, sync2, prev, edge_det, ilr, pend, air, air_clr;

  assign wr = bus.cs & ~bus.r_w;
  assign rd = bus.cs & bus.r_w;

  v6525_port #(.WIDTH(WIDTH)) u_port_a (
    .phi2(phi2), .reset(reset),
    .wr_pr(wr && bus.rs == REG_PRA), .wr_ddr(wr && bus.rs == REG_DDRA),
    .data_in(bus.data_in), .pin(pa_in), .ddr(ddra),
    .port_out(pa_out), .port_oe(pa_oe), .rd_val(pra_rd)
  );

  v6525_port #(.WIDTH(WIDTH)) u_port_b (
    .phi2(phi2), .reset(reset),
    .wr_pr(wr && bus.rs == REG_PRB), .wr_ddr(wr && bus.rs == REG_DDRB),
    .data_in(bus.data_in), .pin(pb_in), .ddr(ddrb),
    .port_out(pb_out), .port_oe(pb_oe), .rd_val(prb_rd)
  );

  v6525_port #(.WIDTH(WIDTH)) u_port_c (
    .phi2(phi2), .reset(reset),
    .wr_pr(wr && bus.rs == REG_PRC), .wr_ddr(wr && bus.rs == REG_DDRC),
    .data_in(bus.data_in), .pin(pc_in), .ddr(ddrc),
    .port_out(pc_out_port), .port_oe(pc_oe_port), .rd_val(prc_rd)
  );

  assign mc      = cr[CR_MC];
  assign ep      = cr[CR_EP];
  assign mc_drop = mc & wr & (bus.rs == REG_CR) & ~bus.data_in[CR_MC];
  assign air_rd  = rd & (bus.rs == REG_AIR);

  // control register keeps only the mode and edge-polarity bits
  always_ff @(posedge phi2) begin
    if (reset)                         cr <= '0;
    else if (wr && bus.rs == REG_CR)   cr <= bus.data_in[CR_W-1:0];
  end

  // two-stage synchronizer plus previous-value stage for edge detection
  always_ff @(posedge phi2) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= pc_in[NIRQ-1:0];
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det = ep ? (sync2 & ~prev) : (~sync2 & prev);
  assign air_clr  = air_rd ? air : '0;

  // ILR: new edges (only in interrupt mode) override the acknowledge clear
  always_ff @(posedge phi2) begin
    if (reset || mc_drop) ilr <= '0;
    else                  ilr <= (ilr & ~air_clr) | (mc ? edge_det : '0);
  end

  assign pend    = ilr & ddrc[NIRQ-1:0];
  assign irq_act = mc & (|pend);

  // priority encoder: the highest pending index ends up as the one-hot AIR value
  always_comb begin
    air = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (pend[i]) begin
        air    = '0;
        air[i] = 1'b1;
      end
    end
  end

  // port C pins switch to interrupt inputs plus irq_n in interrupt mode
  always_comb begin
    pc_out = pc_out_port;
    pc_oe  = pc_oe_port;
    if (mc) begin
      pc_out[NIRQ-1:0] = '0;
      pc_oe[NIRQ-1:0]  = '0;
      pc_out[NIRQ]     = 1'b0;
      pc_oe[NIRQ]      = irq_act;
    end
  end

  // register read mux, combinational from rs and current state
  always_comb begin
    bus.data_out = '0;
    case (bus.rs)
      REG_PRA:  bus.data_out = pra_rd;
      REG_PRB:  bus.data_out = prb_rd;
      REG_PRC: begin
        bus.data_out = prc_rd;
        if (mc) bus.data_out[NIRQ-1:0] = ilr;
      end
      REG_DDRA: bus.data_out = ddra;
      REG_DDRB: bus.data_out = ddrb;
      REG_DDRC: bus.data_out = ddrc;
      REG_CR:   bus.data_out[CR_W-1:0] = cr;
      default:  bus.data_out[NIRQ-1:0] = air;
    endcase
  end

  assign bus.data_oe = rd;

endmodule

// File: tb/tb_v6525_pio.sv
// tb/tb_v6525_pio.sv - self-checking bench for v6525_pio with a behavioural reference model
module tb_v6525_pio;

  localparam int W = 8;
  localparam int N = 5;

  logic         phi2 = 1'b0;
  logic         reset;
  logic [W-1:0] pa_in, pb_in, pc_in;
  logic [W-1:0] pa_out, pb_out, pc_out, pa_oe, pb_oe, pc_oe;

  int n_tests = 0;
  int n_fail  = 0;

  v6525_pio_if #(.WIDTH(W)) bus ();

  v6525_pio #(.WIDTH(W), .NIRQ(N)) dut (
    .phi2(phi2), .reset(reset), .bus(bus),
    .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
    .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
    .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_oe(pc_oe)
  );

  always #5 phi2 = ~phi2;

  // reference model state
  logic [W-1:0] m_pr  [3];
  logic [W-1:0] m_ddr [3];
  logic [1:0]   m_cr;
  logic [N-1:0] m_ilr;
  logic [N-1:0] hist  [3];   // pin samples at the last three edges, [0] oldest

  function automatic logic [N-1:0] m_pend();
    return m_ilr & m_ddr[2][N-1:0];
  endfunction

  function automatic logic [N-1:0] m_air();
    logic [N-1:0] p;
    p = m_pend();
    for (int i = N - 1; i >= 0; i--)
      if (p[i]) return N'(1 << i);
    return '0;
  endfunction

  function automatic logic [W-1:0] m_prd(input int p, input logic [W-1:0] pin);
    return (m_ddr[p] & m_pr[p]) | (~m_ddr[p] & pin);
  endfunction

  function automatic logic [W-1:0] exp_read(input logic [2:0] r);
    logic [W-1:0] v;
    v = '0;
    case (r)
      3'd0: v = m_prd(0, pa_in);
      3'd1: v = m_prd(1, pb_in);
      3'd2: begin
        v = m_prd(2, pc_in);
        if (m_cr[0]) v[N-1:0] = m_ilr;
      end
      3'd3, 3'd4, 3'd5: v = m_ddr[r - 3'd3];
      3'd6: v[1:0] = m_cr;
      default: v[N-1:0] = m_air();
    endcase
    return v;
  endfunction

  function automatic logic [W-1:0] exp_pc_oe();
    logic [W-1:0] v;
    v = m_ddr[2];
    if (m_cr[0]) begin
      v[N-1:0] = '0;
      v[N]     = |m_pend();
    end
    return v;
  endfunction

  function automatic logic [W-1:0] exp_pc_out();
    logic [W-1:0] v;
    v = m_pr[2];
    if (m_cr[0]) v[N:0] = '0;
    return v;
  endfunction

  function automatic void model_step();
    logic [N-1:0] edges, nilr;
    logic         mc;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_pr[i]  = '0;
        m_ddr[i] = '0;
        hist[i]  = '0;
      end
      m_cr  = '0;
      m_ilr = '0;
    end else begin
      mc    = m_cr[0];
      edges = m_cr[1] ? (hist[1] & ~hist[0]) : (~hist[1] & hist[0]);
      nilr  = m_ilr;
      if (bus.cs && bus.r_w && bus.rs == 3'd7) nilr = nilr & ~m_air();
      if (mc) nilr = nilr | edges;
      if (bus.cs && !bus.r_w) begin
        case (bus.rs)
          3'd0, 3'd1, 3'd2: m_pr[bus.rs] = bus.data_in;
          3'd3, 3'd4, 3'd5: m_ddr[bus.rs - 3'd3] = bus.data_in;
          3'd6: begin
            if (mc && !bus.data_in[0]) nilr = '0;
            m_cr = bus.data_in[1:0];
          end
          default: ;
        endcase
      end
      m_ilr   = nilr;
      hist[0] = hist[1];
      hist[1] = hist[2];
      hist[2] = pc_in[N-1:0];
    end
  endfunction

  task automatic tick();
    @(posedge phi2);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] r, input logic [W-1:0] d);
    bus.cs = 1'b1; bus.r_w = 1'b0; bus.rs = r; bus.data_in = d;
    tick();
    bus.cs = 1'b0; bus.r_w = 1'b1;
  endtask

  task automatic sel_rd(input logic [2:0] r);
    bus.cs = 1'b1; bus.r_w = 1'b1; bus.rs = r;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cs = 1'b1; bus.r_w = 1'b0; bus.rs = 3'd3; bus.data_in = 8'hFF;
    ticks(2);
    reset = 1'b0;
    sel_rd(3'd3);
    n_tests++;
    if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_ddra got %h want 00", bus.data_out); end
    n_tests++;
    if ({pa_oe, pb_oe, pc_oe, pa_out, pb_out, pc_out} !== '0) begin
      n_fail++; $display("FAIL reset_ports oe %h %h %h out %h %h %h want all 0", pa_oe, pb_oe, pc_oe, pa_out, pb_out, pc_out);
    end
    n_tests++;
    if (bus.data_oe !== 1'b1) begin n_fail++; $display("FAIL reset_data_oe_rd got %b want 1", bus.data_oe); end
    bus.cs = 1'b0; #1;
    n_tests++;
    if (bus.data_oe !== 1'b0) begin n_fail++; $display("FAIL data_oe_idle got %b want 0", bus.data_oe); end
  endtask

  task automatic test_port_a();
    pa_in = 8'h0C;
    wr(3'd3, 8'hF0);
    wr(3'd0, 8'h5A);
    sel_rd(3'd0);
    n_tests++;
    if (pa_oe !== 8'hF0) begin n_fail++; $display("FAIL pa_oe got %h want f0", pa_oe); end
    n_tests++;
    if (pa_out !== 8'h5A) begin n_fail++; $display("FAIL pa_out got %h want 5a", pa_out); end
    n_tests++;
    if (bus.data_out !== 8'h5C) begin n_fail++; $display("FAIL pra_read got %h want 5c", bus.data_out); end
    bus.cs = 1'b0;
  endtask

  task automatic test_irq_latency();
    wr(3'd6, 8'h03);
    wr(3'd5, 8'h1F);
    ticks(3);
    sel_rd(3'd2);
    pc_in[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if (bus.data_out[N-1:0] !== 5'h00) begin n_fail++; $display("FAIL irq_early edge%0d ilr %h want 00", k, bus.data_out[N-1:0]); end
    end
    tick();
    n_tests++;
    if (bus.data_out[N-1:0] !== 5'h04) begin n_fail++; $display("FAIL irq_set ilr %h want 04", bus.data_out[N-1:0]); end
    n_tests++;
    if (pc_oe[N] !== 1'b1 || pc_out[N] !== 1'b0) begin n_fail++; $display("FAIL irq_low oe %b out %b want 1 0", pc_oe[N], pc_out[N]); end
    sel_rd(3'd7);
    n_tests++;
    if (bus.data_out !== 8'h04) begin n_fail++; $display("FAIL air_first got %h want 04", bus.data_out); end
    tick();
    sel_rd(3'd2);
    n_tests++;
    if (bus.data_out[N-1:0] !== 5'h00 || pc_oe[N] !== 1'b0) begin
      n_fail++; $display("FAIL irq_ack ilr %h oe %b want 00 0", bus.data_out[N-1:0], pc_oe[N]);
    end
    bus.cs = 1'b0;
  endtask

  task automatic test_priority();
    logic [W-1:0] want [3];
    want[0] = 8'h08; want[1] = 8'h02; want[2] = 8'h00;
    pc_in[1] = 1'b1; pc_in[3] = 1'b1;
    ticks(3);
    for (int i = 0; i < 3; i++) begin
      sel_rd(3'd7);
      n_tests++;
      if (bus.data_out !== want[i]) begin n_fail++; $display("FAIL air_prio%0d got %h want %h", i, bus.data_out, want[i]); end
      tick();
    end
    bus.cs = 1'b0;
  endtask

  task automatic test_mask();
    wr(3'd5, 8'h00);
    pc_in[0] = 1'b1;
    ticks(3);
    sel_rd(3'd2);
    n_tests++;
    if (bus.data_out[0] !== 1'b1 || pc_oe[N] !== 1'b0) begin
      n_fail++; $display("FAIL mask_latch ilr0 %b oe %b want 1 0", bus.data_out[0], pc_oe[N]);
    end
    wr(3'd5, 8'h01);
    n_tests++;
    if (pc_oe[N] !== 1'b1 || pc_out[N] !== 1'b0) begin n_fail++; $display("FAIL unmask_irq oe %b out %b want 1 0", pc_oe[N], pc_out[N]); end
    sel_rd(3'd7);
    n_tests++;
    if (bus.data_out !== 8'h01) begin n_fail++; $display("FAIL unmask_air got %h want 01", bus.data_out); end
    tick();
    bus.cs = 1'b0;
  endtask

  task automatic test_set_wins();
    wr(3'd5, 8'h1F);
    pc_in[4] = 1'b0;
    ticks(3);
    pc_in[4] = 1'b1; tick();
    pc_in[4] = 1'b0; tick();
    pc_in[4] = 1'b1; tick();
    tick();
    sel_rd(3'd7);
    n_tests++;
    if (bus.data_out !== 8'h10) begin n_fail++; $display("FAIL setwin_air got %h want 10", bus.data_out); end
    tick();
    sel_rd(3'd2);
    n_tests++;
    if (bus.data_out[4] !== 1'b1) begin n_fail++; $display("FAIL setwin_keep ilr4 %b want 1", bus.data_out[4]); end
    sel_rd(3'd7);
    tick();
    sel_rd(3'd2);
    n_tests++;
    if (bus.data_out[N-1:0] !== 5'h00) begin n_fail++; $display("FAIL setwin_clear ilr %h want 00", bus.data_out[N-1:0]); end
    bus.cs = 1'b0;
  endtask

  task automatic test_mc_clear();
    pc_in[0] = 1'b0; ticks(3);
    pc_in[0] = 1'b1; ticks(3);
    n_tests++;
    if (pc_oe[N] !== 1'b1) begin n_fail++; $display("FAIL mc_pre oe %b want 1", pc_oe[N]); end
    wr(3'd6, 8'h00);
    n_tests++;
    if (pc_oe[N] !== 1'b0) begin n_fail++; $display("FAIL mc_drop oe %b want 0", pc_oe[N]); end
    wr(3'd6, 8'h03);
    sel_rd(3'd2);
    n_tests++;
    if (bus.data_out[N-1:0] !== 5'h00) begin n_fail++; $display("FAIL mc_ilr ilr %h want 00", bus.data_out[N-1:0]); end
    bus.cs = 1'b0;
  endtask

  task automatic test_falling();
    wr(3'd6, 8'h01);
    pc_in[1] = 1'b0;
    ticks(3);
    sel_rd(3'd7);
    n_tests++;
    if (bus.data_out !== 8'h02) begin n_fail++; $display("FAIL fall_air got %h want 02", bus.data_out); end
    tick();
    bus.cs = 1'b0;
    wr(3'd6, 8'h03);
  endtask

  task automatic test_reset_discard();
    pc_in = 8'h00;
    ticks(4);
    pc_in[1] = 1'b1; tick();
    pc_in[1] = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({pa_oe, pb_oe, pc_oe} !== '0) begin n_fail++; $display("FAIL rst_oe got %h %h %h want 0", pa_oe, pb_oe, pc_oe); end
    wr(3'd6, 8'h03);
    wr(3'd5, 8'h1F);
    ticks(4);
    sel_rd(3'd2);
    n_tests++;
    if (bus.data_out[N-1:0] !== 5'h00 || pc_oe[N] !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard ilr %h oe %b want 00 0", bus.data_out[N-1:0], pc_oe[N]);
    end
    bus.cs = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 59) == 0);
      bus.cs      = $urandom_range(0, 1);
      bus.r_w     = ($urandom_range(0, 3) != 0);
      bus.rs      = 3'($urandom_range(0, 7));
      bus.data_in = 8'($urandom);
      if (bus.rs == 3'd6 && $urandom_range(0, 3) != 0) bus.data_in[0] = 1'b1;
      pa_in = 8'($urandom);
      pb_in = 8'($urandom);
      if ($urandom_range(0, 2) == 0) pc_in = pc_in ^ 8'(1 << $urandom_range(0, W - 1));
      #1;
      n_tests++;
      if (bus.data_out !== exp_read(bus.rs)) begin
        n_fail++; $display("FAIL rnd_read c%0d rs %0d got %h want %h", c, bus.rs, bus.data_out, exp_read(bus.rs));
      end
      n_tests++;
      if (bus.data_oe !== (bus.cs & bus.r_w)) begin n_fail++; $display("FAIL rnd_data_oe c%0d got %b", c, bus.data_oe); end
      n_tests++;
      if (pa_out !== m_pr[0] || pa_oe !== m_ddr[0]) begin
        n_fail++; $display("FAIL rnd_pa c%0d out %h oe %h want %h %h", c, pa_out, pa_oe, m_pr[0], m_ddr[0]);
      end
      n_tests++;
      if (pb_out !== m_pr[1] || pb_oe !== m_ddr[1]) begin
        n_fail++; $display("FAIL rnd_pb c%0d out %h oe %h want %h %h", c, pb_out, pb_oe, m_pr[1], m_ddr[1]);
      end
      n_tests++;
      if (pc_out !== exp_pc_out() || pc_oe !== exp_pc_oe()) begin
        n_fail++; $display("FAIL rnd_pc c%0d out %h oe %h want %h %h", c, pc_out, pc_oe, exp_pc_out(), exp_pc_oe());
      end
      tick();
    end
    reset  = 1'b0;
    bus.cs = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_pr[i] = '0; m_ddr[i] = '0; hist[i] = '0;
    end
    m_cr = '0; m_ilr = '0;
    reset = 1'b0;
    bus.cs = 1'b0; bus.r_w = 1'b1; bus.rs = 3'd0; bus.data_in = '0;
    pa_in = '0; pb_in = '0; pc_in = '0;
    test_reset();
    test_port_a();
    test_irq_latency();
    test_priority();
    test_mask();
    test_set_wins();
    test_mc_clear();
    test_falling();
    test_reset_discard();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/v6525_pio.md
V6525_PIO -- requirements
Module: v6525_pio

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each port and the data bus.
REQ-002 Parameter NIRQ, default 5, number of port C interrupt inputs; legal range 1..WIDTH-1.
REQ-003 phi2  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cs  input  1  chip select, active-high, sampled on phi2.
REQ-006 r_w  input  1  1 = read, 0 = write.
REQ-007 rs  input  3  register select.
REQ-008 data_in  input  WIDTH  CPU write data.
REQ-009 data_out  output  WIDTH  CPU read data.
REQ-010 data_oe  output  1  data_out drive enable; equals cs & r_w.
REQ-011 pa_in / pb_in / pc_in  input  WIDTH each  port pin levels.
REQ-012 pa_out / pb_out / pc_out  output  WIDTH each  port drive values.
REQ-013 pa_oe / pb_oe / pc_oe  output  WIDTH each  per-bit drive enables.

Function
REQ-014 Register map: 0 PRA, 1 PRB, 2 PRC, 3 DDRA, 4 DDRB, 5 DDRC, 6 CR, 7 AIR.
REQ-015 Write: when cs & !r_w at a phi2 edge, the selected register loads data_in; writes to AIR are ignored.
REQ-016 CR uses 2 bits: CR[0] MC (interrupt mode), CR[1] EP (1 = rising, 0 = falling edge detect); all other CR bits read 0.
REQ-017 Port A/B and port C with MC=0: oe = DDR bit; out = PR bit; read of PRx returns DDR ? PR : pin, per bit.
REQ-018 Reads of DDRx and CR return the register; data_out is combinational from rs and the current state.
REQ-019 With MC=1: pc bits [NIRQ-1:0] are interrupt inputs, oe = 0; DDRC bits [NIRQ-1:0] act as the interrupt mask.
REQ-020 With MC=1: pc bit NIRQ is irq_n: oe = 1 and out = 0 while any (ILR & mask) bit is set; otherwise oe = 0.
REQ-021 With MC=1: remaining pc bits above NIRQ behave as in REQ-017.
REQ-022 Each interrupt input passes through a 2-flop synchronizer plus a previous-value flop; the edge is per EP.
REQ-023 Latency: a pin edge before phi2 edge k sets the ILR bit after edge k+2; irq_n follows in the same cycle.
REQ-024 With MC=1: PRC read returns ILR in bits [NIRQ-1:0] and REQ-017 values above.
REQ-025 AIR read value is one-hot: the highest-index set bit of ILR & mask; 0 if none.
REQ-026 An AIR read cycle (cs & r_w, rs=7) clears that one ILR bit at the cycle's phi2 edge.
REQ-027 Simultaneous new edge and AIR clear on the same bit: set wins and the bit stays 1.
REQ-028 Masked bits still latch in ILR; unmasking a latched bit asserts irq_n in the next cycle.
REQ-029 MC changing 1->0 clears ILR and releases irq_n on the same edge.
REQ-030 Edges are not latched while MC=0.

Reset
REQ-031 reset at a phi2 edge clears PRA/B/C, DDRA/B/C, CR, ILR and the synchronizers; reset has priority over writes.
REQ-032 During and after reset, all port oe = 0, out = 0, irq_n is released, data_oe follows REQ-010.
REQ-033 Reset asserted mid-sequence (pending edge in the synchronizer) discards the edge; nothing is latched after release.

Structure
REQ-034 Shared package v6525_pkg holds register address constants (REG_PRA..REG_AIR) and CR bit indices (CR_MC, CR_EP).
REQ-035 One sub-module, v6525_port, implements one WIDTH-bit port (PR, DDR, oe/out/read mux); instantiated three times.
REQ-036 Interrupt logic (synchronizer, ILR, priority encoder) sits in v6525_pio; the priority encoder is a parametrised loop over NIRQ.

Verification
REQ-037 Reset, then write DDRA=0xF0 and PRA=0x5A; drive pa_in=0x0C -> pa_oe=0xF0, pa_out=0x5A, PRA read=0x5C.
REQ-038 CR=0x03, DDRC=0x1F; raise pc_in[2] before edge k -> ILR[2]=1 after k+2, irq_n driven low; AIR read=0x04, then ILR=0, irq_n released.
REQ-039 Edges on pc_in[1] and pc_in[3] together -> AIR=0x08, then AIR=0x02 on the next read, then 0x00.
REQ-040 DDRC=0x00 with a pending edge on bit 0 -> ILR[0]=1, irq_n released; write DDRC=0x01 -> irq_n low the next cycle.
REQ-041 AIR read clears bit 4 while a new bit-4 edge arrives in the same cycle -> ILR[4] stays 1.
REQ-042 Edge in the synchronizer, reset pulse for 1 cycle -> ILR=0 and all oe=0 after release.
